// File: rtl/wb_unit.sv
// Writeback unit for the RV32I core: arbitrates ALU results and load returns onto the
// register file write port, and tracks outstanding-load destinations for decode hazard stalls.
module wb_unit #(
  parameter int unsigned MAX_LD = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_issue,
  input  logic [4:0]  ld_issue_rd,
  output logic        ld_issue_ready,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        stall,
  output logic        write_en,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic [2:0]  ld_count,
  output logic        err
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREGS  = 32;

  // Bit 0 is never set, so x0 can never appear busy.
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic              err_nxt;
  logic              write_en_nxt;
  logic [REG_W-1:0]  write_reg_nxt;
  logic [DATA_W-1:0] write_data_nxt;
  logic              issue_acc;
  logic              ret_acc;
  logic              ret_counted;

  // Handshake and hazard outputs, all from registered state plus current requests.
  always_comb begin
    ld_ready       = !alu_valid;
    ld_issue_ready = (ld_count < CNT_W'(MAX_LD)) &&
                     ((ld_issue_rd == REG_W'(0)) || !busy[ld_issue_rd]);
    stall          = ((rs1 != REG_W'(0)) && busy[rs1]) ||
                     ((rs2 != REG_W'(0)) && busy[rs2]);
  end

  // Next-state for scoreboard, counter, error flag and write port.
  always_comb begin
    issue_acc      = ld_issue && ld_issue_ready;
    ret_acc        = ld_valid && !alu_valid;
    ret_counted    = ret_acc && (ld_count != CNT_W'(0));
    busy_nxt       = busy;
    count_nxt      = ld_count;
    err_nxt        = err;
    write_en_nxt   = 1'b0;
    write_reg_nxt  = write_reg;
    write_data_nxt = write_data;

    if (ret_acc) begin
      busy_nxt[ld_rd] = 1'b0;
    end
    if (issue_acc && (ld_issue_rd != REG_W'(0))) begin
      busy_nxt[ld_issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;

    if (issue_acc && !ret_counted) begin
      count_nxt = ld_count + CNT_W'(1);
    end else if (!issue_acc && ret_counted) begin
      count_nxt = ld_count - CNT_W'(1);
    end

    // A return with nothing outstanding or an ALU write to a pending register is a violation.
    if ((ret_acc && (ld_count == CNT_W'(0))) || (alu_valid && busy[alu_rd])) begin
      err_nxt = 1'b1;
    end

    if (alu_valid) begin
      write_en_nxt   = (alu_rd != REG_W'(0));
      write_reg_nxt  = alu_rd;
      write_data_nxt = alu_data;
    end else if (ret_acc) begin
      write_en_nxt   = (ld_rd != REG_W'(0));
      write_reg_nxt  = ld_rd;
      write_data_nxt = ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      ld_count   <= '0;
      err        <= 1'b0;
      write_en   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      busy       <= busy_nxt;
      ld_count   <= count_nxt;
      err        <= err_nxt;
      write_en   <= write_en_nxt;
      write_reg  <= write_reg_nxt;
      write_data <= write_data_nxt;
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed scenarios followed by randomized traffic
// compared against a scoreboard model built from arrays and integer counters.
module tb_wb_unit;

  localparam int unsigned MAX_LD = 2;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_issue_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        stall;
  logic        write_en;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [2:0]  ld_count;
  logic        err;

  int errors = 0;
  int checks = 0;

  wb_unit #(.MAX_LD(MAX_LD)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .rs1(rs1), .rs2(rs2), .stall(stall),
    .write_en(write_en), .write_reg(write_reg), .write_data(write_data),
    .ld_count(ld_count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_issue = 1'b0; ld_issue_rd = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    rs1 = '0; rs2 = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL reset_we got=%0b exp=0", write_en); end
    checks++; if (write_reg !== 5'd0) begin errors++; $display("FAIL reset_wreg got=%0d exp=0", write_reg); end
    checks++; if (write_data !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", write_data); end
    checks++; if (ld_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", ld_count); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", err); end
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    alu_valid = 1'b0;
    checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL alu_we got=%0b exp=1", write_en); end
    checks++; if (write_reg !== 5'd5) begin errors++; $display("FAIL alu_wreg got=%0d exp=5", write_reg); end
    checks++; if (write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_wdata got=%h exp=deadbeef", write_data); end
    step();
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL alu_we_drop got=%0b exp=0", write_en); end
    checks++; if (write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_hold got=%h exp=deadbeef", write_data); end
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1;
    step();
    alu_valid = 1'b0;
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL alu_x0_we got=%0b exp=0", write_en); end
  endtask

  task automatic test_load_hazard();
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    #1;
    checks++; if (ld_issue_ready !== 1'b1) begin errors++; $display("FAIL hz_issue_ready got=%0b exp=1", ld_issue_ready); end
    step();
    ld_issue = 1'b0; rs1 = 5'd7;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hz_stall got=%0b exp=1", stall); end
    checks++; if (ld_count !== 3'd1) begin errors++; $display("FAIL hz_count got=%0d exp=1", ld_count); end
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h1234;
    #1;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL hz_ld_ready got=%0b exp=1", ld_ready); end
    step();
    ld_valid = 1'b0;
    #1;
    checks++; if (write_en !== 1'b1 || write_reg !== 5'd7 || write_data !== 32'h1234)
      begin errors++; $display("FAIL hz_write got=%0b/%0d/%h exp=1/7/1234", write_en, write_reg, write_data); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hz_stall_clear got=%0b exp=0", stall); end
    checks++; if (ld_count !== 3'd0) begin errors++; $display("FAIL hz_count_clear got=%0d exp=0", ld_count); end
    idle();
    step();
  endtask

  task automatic test_arbitration();
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    step();
    ld_issue = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA;
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'hB;
    #1;
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL arb_ld_ready got=%0b exp=0", ld_ready); end
    step();
    alu_valid = 1'b0;
    checks++; if (write_en !== 1'b1 || write_reg !== 5'd3 || write_data !== 32'hA)
      begin errors++; $display("FAIL arb_alu_write got=%0b/%0d/%h exp=1/3/a", write_en, write_reg, write_data); end
    step();
    ld_valid = 1'b0;
    checks++; if (write_en !== 1'b1 || write_reg !== 5'd9 || write_data !== 32'hB)
      begin errors++; $display("FAIL arb_ld_write got=%0b/%0d/%h exp=1/9/b", write_en, write_reg, write_data); end
    checks++; if (ld_count !== 3'd0 || err !== 1'b0) begin errors++; $display("FAIL arb_state got=%0d/%0b exp=0/0", ld_count, err); end
    idle();
  endtask

  task automatic test_capacity();
    ld_issue = 1'b1; ld_issue_rd = 5'd1;
    step();
    ld_issue_rd = 5'd2;
    step();
    ld_issue_rd = 5'd4;
    #1;
    checks++; if (ld_issue_ready !== 1'b0) begin errors++; $display("FAIL cap_full_ready got=%0b exp=0", ld_issue_ready); end
    checks++; if (ld_count !== 3'd2) begin errors++; $display("FAIL cap_count got=%0d exp=2", ld_count); end
    step();
    checks++; if (ld_count !== 3'd2) begin errors++; $display("FAIL cap_refused_count got=%0d exp=2", ld_count); end
    ld_issue = 1'b0; ld_valid = 1'b1; ld_rd = 5'd1; ld_data = 32'h11;
    step();
    checks++; if (ld_count !== 3'd1) begin errors++; $display("FAIL cap_ret_count got=%0d exp=1", ld_count); end
    ld_issue = 1'b1; ld_issue_rd = 5'd4; ld_rd = 5'd2; ld_data = 32'h22;
    step();
    checks++; if (ld_count !== 3'd1) begin errors++; $display("FAIL cap_simul_count got=%0d exp=1", ld_count); end
    ld_valid = 1'b0; ld_issue_rd = 5'd4; rs2 = 5'd4;
    #1;
    checks++; if (ld_issue_ready !== 1'b0) begin errors++; $display("FAIL cap_waw_ready got=%0b exp=0", ld_issue_ready); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL cap_rs2_stall got=%0b exp=1", stall); end
    step();
    checks++; if (ld_count !== 3'd1) begin errors++; $display("FAIL cap_waw_count got=%0d exp=1", ld_count); end
    ld_issue = 1'b0; ld_valid = 1'b1; ld_rd = 5'd4;
    step();
    idle();
    checks++; if (ld_count !== 3'd0 || err !== 1'b0) begin errors++; $display("FAIL cap_end got=%0d/%0b exp=0/0", ld_count, err); end
  endtask

  task automatic test_violations();
    ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'h55;
    step();
    ld_valid = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL vio_ret_err got=%0b exp=1", err); end
    checks++; if (write_en !== 1'b1 || write_reg !== 5'd12 || write_data !== 32'h55)
      begin errors++; $display("FAIL vio_ret_write got=%0b/%0d/%h exp=1/12/55", write_en, write_reg, write_data); end
    checks++; if (ld_count !== 3'd0) begin errors++; $display("FAIL vio_ret_count got=%0d exp=0", ld_count); end
    pulse_reset();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL vio_err_reset got=%0b exp=0", err); end
    ld_issue = 1'b1; ld_issue_rd = 5'd6;
    step();
    ld_issue = 1'b0; alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66; rs1 = 5'd6;
    step();
    alu_valid = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL vio_alu_err got=%0b exp=1", err); end
    checks++; if (write_en !== 1'b1 || write_reg !== 5'd6) begin errors++; $display("FAIL vio_alu_write got=%0b/%0d exp=1/6", write_en, write_reg); end
    checks++; if (stall !== 1'b1 || ld_count !== 3'd1) begin errors++; $display("FAIL vio_busy_kept got=%0b/%0d exp=1/1", stall, ld_count); end
    step(); step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL vio_sticky got=%0b exp=1", err); end
    ld_valid = 1'b1; ld_rd = 5'd6;
    step();
    idle();
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    ld_issue = 1'b1; ld_issue_rd = 5'd1;
    step();
    ld_issue_rd = 5'd2; alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hCAFE;
    step();
    idle();
    rs1 = 5'd1;
    checks++; if (write_en !== 1'b1 || ld_count !== 3'd2) begin errors++; $display("FAIL mid_setup got=%0b/%0d exp=1/2", write_en, ld_count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (write_en !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0)
      begin errors++; $display("FAIL mid_write_clear got=%0b/%0d/%h exp=0/0/0", write_en, write_reg, write_data); end
    checks++; if (ld_count !== 3'd0 || stall !== 1'b0 || err !== 1'b0)
      begin errors++; $display("FAIL mid_state_clear got=%0d/%0b/%0b exp=0/0/0", ld_count, stall, err); end
    #1 rst_n = 1'b1;
    ld_valid = 1'b1; ld_rd = 5'd1; ld_data = 32'h77;
    step();
    idle();
    checks++; if (err !== 1'b1 || write_en !== 1'b1 || ld_count !== 3'd0)
      begin errors++; $display("FAIL mid_stale_ret got=%0b/%0b/%0d exp=1/1/0", err, write_en, ld_count); end
  endtask

  task automatic test_random();
    bit          busy_m [32];
    int          cnt_m;
    bit          err_m;
    bit          we_m;
    logic [4:0]  wr_m;
    logic [31:0] wd_m;
    bit          hold;
    bit          e_lr, e_ir, e_st, acc_ret, acc_iss;
    int          blist[$];

    idle();
    pulse_reset();
    for (int r = 0; r < 32; r++) busy_m[r] = 1'b0;
    cnt_m = 0; err_m = 1'b0; we_m = 1'b0; wr_m = '0; wd_m = '0; hold = 1'b0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      alu_valid   = ($urandom_range(0, 99) < 35);
      alu_rd      = 5'($urandom_range(0, 31));
      alu_data    = $urandom();
      ld_issue    = ($urandom_range(0, 99) < 40);
      ld_issue_rd = 5'($urandom_range(0, 31));
      rs1         = 5'($urandom_range(0, 31));
      rs2         = 5'($urandom_range(0, 31));
      if (!hold) begin
        blist.delete();
        for (int r = 1; r < 32; r++) if (busy_m[r]) blist.push_back(r);
        ld_valid = 1'b0;
        if (blist.size() > 0 && $urandom_range(0, 99) < 45) begin
          ld_valid = 1'b1;
          ld_rd    = 5'(blist[$urandom_range(0, blist.size() - 1)]);
          ld_data  = $urandom();
        end else if (blist.size() == 0 && $urandom_range(0, 99) < 15) begin
          ld_valid = 1'b1;
          ld_rd    = 5'($urandom_range(0, 31));
          ld_data  = $urandom();
        end
      end
      #1;
      e_lr = !alu_valid;
      e_ir = (cnt_m < int'(MAX_LD)) && (ld_issue_rd == 5'd0 || !busy_m[ld_issue_rd]);
      e_st = (rs1 != 5'd0 && busy_m[rs1]) || (rs2 != 5'd0 && busy_m[rs2]);
      checks++; if (ld_ready !== e_lr) begin errors++; $display("FAIL rnd_ld_ready cyc=%0d got=%0b exp=%0b", cyc, ld_ready, e_lr); end
      checks++; if (ld_issue_ready !== e_ir) begin errors++; $display("FAIL rnd_issue_ready cyc=%0d got=%0b exp=%0b", cyc, ld_issue_ready, e_ir); end
      checks++; if (stall !== e_st) begin errors++; $display("FAIL rnd_stall cyc=%0d got=%0b exp=%0b", cyc, stall, e_st); end

      acc_ret = ld_valid && e_lr;
      acc_iss = ld_issue && e_ir;
      if (alu_valid) begin
        if (alu_rd != 5'd0 && busy_m[alu_rd]) err_m = 1'b1;
        we_m = (alu_rd != 5'd0); wr_m = alu_rd; wd_m = alu_data;
      end else if (acc_ret) begin
        we_m = (ld_rd != 5'd0); wr_m = ld_rd; wd_m = ld_data;
      end else begin
        we_m = 1'b0;
      end
      if (acc_ret) begin
        if (cnt_m == 0) err_m = 1'b1;
        else cnt_m--;
        busy_m[ld_rd] = 1'b0;
      end
      if (acc_iss) begin
        cnt_m++;
        if (ld_issue_rd != 5'd0) busy_m[ld_issue_rd] = 1'b1;
      end
      hold = ld_valid && !acc_ret;

      step();
      checks++; if (write_en !== we_m) begin errors++; $display("FAIL rnd_we cyc=%0d got=%0b exp=%0b", cyc, write_en, we_m); end
      checks++; if (write_reg !== wr_m) begin errors++; $display("FAIL rnd_wreg cyc=%0d got=%0d exp=%0d", cyc, write_reg, wr_m); end
      checks++; if (write_data !== wd_m) begin errors++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, write_data, wd_m); end
      checks++; if (ld_count !== 3'(cnt_m)) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, ld_count, cnt_m); end
      checks++; if (err !== err_m) begin errors++; $display("FAIL rnd_err cyc=%0d got=%0b exp=%0b", cyc, err, err_m); end
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_alu();
    test_load_hazard();
    test_arbitration();
    test_capacity();
    test_violations();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
